// File: rtl/ext_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_bus_pkg
// Description : Shared types, widths and address-decode helpers for the
//               external bus responder.
//               Contents: state_t (responder FSM states), ADDR_W / DATA_W /
//               BE_W bus widths, addr_in_range(), word_index().
// Revision    : 1.0 - initial release
// ============================================================================
package ext_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_ACK     = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  // The limit is formed in ADDR_W+1 bits so that a window ending exactly at
  // the top of the 4 GiB space does not wrap to zero.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] base,
                                         input int unsigned       words);
    logic [ADDR_W:0] lim;
    lim = {1'b0, base} + ((ADDR_W+1)'(words) << 2);
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < lim);
  endfunction

  // Word offset from the window base; the byte-lane bits drop out.
  function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W-1:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ext_bus_resp_ram.sv
`default_nettype none
// ============================================================================
// Module      : ext_bus_resp_ram
// Description : Single-port, byte-enabled MEM_WORDS x 32 RAM with a
//               registered read port (one-cycle latency, block-RAM style).
//               Contents are not reset.
// Ports       : i_clk   - clock
//               i_we    - write strobe (bytes gated by i_be)
//               i_re    - read strobe (o_rdata updates the next edge)
//               i_be    - byte enables, bit i covers data[8i+7:8i]
//               i_addr  - word address
//               i_wdata - write data
//               o_rdata - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module ext_bus_resp_ram
  import ext_bus_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_we,
  input  logic                         i_re,
  input  logic [BE_W-1:0]              i_be,
  input  logic [$clog2(MEM_WORDS)-1:0] i_addr,
  input  logic [DATA_W-1:0]            i_wdata,
  output logic [DATA_W-1:0]            o_rdata
);

  logic [DATA_W-1:0] r_mem [MEM_WORDS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ext_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : ext_bus_responder
// Description : Responder end of the external bus. Captures one single-word
//               request, inserts WAIT_CYCLES wait states, services it from an
//               on-chip byte-enabled RAM window at BASE_ADDR and returns a
//               one-cycle acknowledge, followed by one recovery cycle.
// Ports       : CLOCK_50    - clock (rising edge)
//               reset_n     - synchronous active-low reset
//               address     - byte address (bits [1:0] ignored)
//               byte_enable - write byte mask
//               read/write  - request strobes
//               write_data  - write data
//               acknowledge - one-cycle completion pulse
//               read_data   - read result, zero outside acknowledge
//               busy        - transaction in flight (capture .. RECOVER)
//               err_count   - saturating error counter (optional)
// Options     : EXT_BUS_RESP_ERR_COUNT_EN - adds err_count port and logic
// Revision    : 1.0 - initial release
// ============================================================================
module ext_bus_responder
  import ext_bus_pkg::*;
#(
  parameter int                MEM_WORDS   = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0800_0000,
  parameter int                WAIT_CYCLES = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [BE_W-1:0]   byte_enable,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] write_data,
  output logic              acknowledge,
  output logic [DATA_W-1:0] read_data,
  output logic              busy
`ifdef EXT_BUS_RESP_ERR_COUNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int         c_AW        = $clog2(MEM_WORDS);
  localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata;
  logic              r_op_rd;
  logic              r_op_wr;
  logic [3:0]        r_wait_cnt;
  logic              r_rd_ok;

  logic              w_capture;
  logic              w_in_range;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [c_AW-1:0]   w_index;
  logic [DATA_W-1:0] w_ram_q;

  assign w_capture  = (r_state == ST_IDLE) && (read || write);
  assign w_in_range = addr_in_range(r_addr, BASE_ADDR, MEM_WORDS);
  assign w_index    = c_AW'(word_index(r_addr, BASE_ADDR));

  // Read+write together is serviced as a write, so the read strobe is
  // suppressed whenever the write strobe was captured.
  assign w_ram_we = (r_state == ST_ACCESS) && r_op_wr && w_in_range;
  assign w_ram_re = (r_state == ST_ACCESS) && r_op_rd && !r_op_wr && w_in_range;

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (read || write) w_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT:    if (r_wait_cnt == 4'd0) w_next = ST_ACCESS;
      ST_ACCESS:  w_next = ST_ACK;
      ST_ACK:     w_next = ST_RECOVER;
      ST_RECOVER: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Output logic; the RAM output register supplies the data in ACK.
  always_comb begin
    acknowledge = (r_state == ST_ACK);
    busy        = (r_state != ST_IDLE);
    read_data   = (r_state == ST_ACK && r_rd_ok) ? w_ram_q : '0;
  end

  // Capture registers and wait counter
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_op_rd    <= 1'b0;
      r_op_wr    <= 1'b0;
      r_wait_cnt <= 4'd0;
      r_rd_ok    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr     <= address;
        r_be       <= byte_enable;
        r_wdata    <= write_data;
        r_op_rd    <= read;
        r_op_wr    <= write;
        r_wait_cnt <= c_WAIT_LOAD;
      end else if (r_state == ST_WAIT && r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      // Remembers whether ACK should expose RAM data (in-range read only).
      if (r_state == ST_ACCESS) r_rd_ok <= w_ram_re;
    end
  end

`ifdef EXT_BUS_RESP_ERR_COUNT_EN
  logic [7:0] r_err_cnt;
  logic       w_err;

  // One count per erroneous transaction, taken at the ACCESS edge.
  assign w_err = (r_state == ST_ACCESS) && (!w_in_range || (r_op_rd && r_op_wr));

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n)                            r_err_cnt <= 8'd0;
    else if (w_err && r_err_cnt != 8'hFF)    r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_count = r_err_cnt;
`endif

  ext_bus_resp_ram #(
    .MEM_WORDS (MEM_WORDS)
  ) u_ram (
    .i_clk   (CLOCK_50),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_be    (r_be),
    .i_addr  (w_index),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

endmodule
`default_nettype wire

// File: doc/ext_bus_responder.md
# ext_bus_responder

Responder (slave) end of the team's external bus interface: address, byte_enable, read, write, write_data, acknowledge, read_data. It accepts single-word requests from a bus-master state machine such as the video-copy loop, services them from an on-chip byte-enabled RAM window, and returns a one-cycle acknowledge after a programmable wait. It is used as an on-chip scratch frame/line buffer and as the bench-side model of the bus bridge for initiator verification.

## Interface
- MEM_WORDS, 1024 — number of 32-bit words in the backing RAM; power of two, 16..65536
- BASE_ADDR, 32'h0800_0000 — byte address of word 0
- WAIT_CYCLES, 2 — wait states inserted before the access, 0..15
- CLOCK_50  input  1 — sole clock, all logic on rising edge
- reset_n  input  1 — synchronous, active-low reset
- address  input  32 — byte address from initiator
- byte_enable  input  4 — write byte mask; bit i enables data[8i+7:8i]
- read  input  1 — read request
- write  input  1 — write request
- write_data  input  32 — write data
- acknowledge  output  1 — one-cycle transaction-complete pulse
- read_data  output  32 — read result, valid only while acknowledge=1
- busy  output  1 — high from capture through RECOVER
- err_count  output  8 — protocol/decode error counter (only with macro, see Configuration)

## Operation
- States: IDLE, WAIT, ACCESS, ACK, RECOVER.
- IDLE: if read|write is high, capture address, byte_enable, write_data and the op. Next state is WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT: down-counter loaded with WAIT_CYCLES-1; move to ACCESS when the counter reaches 0.
- ACCESS: compute index = (address-BASE_ADDR)>>2; address[1:0] are ignored.
  - In-range means BASE_ADDR ≤ address < BASE_ADDR+4*MEM_WORDS.
  - Write: update only the enabled bytes. Read: issue a RAM read.
  - Out of range: no RAM access; the read result is forced to 0.
- ACK: acknowledge=1; read_data = RAM output (0 for writes and out-of-range reads). Next state is RECOVER.
- RECOVER: acknowledge=0; read/write are ignored for this one cycle. Next state is IDLE. The initiator must drop its request by the cycle after ACK.
- read and write both high at capture: the write is performed and an error is recorded.
- Request dropped before ACK: the transaction still completes (no abort); no error.
- byte_enable=0 on a write: acknowledged with no RAM change.
- Reset: when reset_n=0 at an edge, state→IDLE, acknowledge=0, read_data=0, busy=0, wait counter=0, err_count=0.
  - A reset during WAIT or ACCESS drops the transaction. A RAM write already committed at an ACCESS edge persists.
  - RAM contents are not cleared.

## Timing
- Request first high in IDLE at cycle t. Capture at the end of t. acknowledge is high in cycle t+2+WAIT_CYCLES, for exactly one cycle.
- Minimum spacing between captures is WAIT_CYCLES+4 cycles.
- read_data is registered and held 0 outside ACK.
- RAM read latency is one cycle: addressed in ACCESS, data in ACK.
- busy rises the cycle after capture and falls on the exit from RECOVER.

## Configuration
- EXT_BUS_RESP_ERR_COUNT_EN defined: err_count is present.
  - It increments (saturating at 255) on each out-of-range access and each simultaneous read+write, at the ACCESS edge.
- Undefined: the err_count port and its logic are absent. Error cases behave identically otherwise.

## Structure
- Package ext_bus_pkg:
  - state enum (IDLE, WAIT, ACCESS, ACK, RECOVER)
  - widths ADDR_W=32, DATA_W=32, BE_W=4
  - in-range/index helper function
- Sub-module ext_bus_resp_ram: single-port, byte-enabled, MEM_WORDS×32, registered read; inferable as M10K.
- The FSM, capture registers, wait counter and error counter live in ext_bus_responder.

## Test plan
- WAIT_CYCLES=2. Write 32'hDEADBEEF, be 4'b1111, address BASE+8 at t=0 → acknowledge only at t=4. Read of BASE+8 then returns read_data 32'hDEADBEEF with acknowledge.
- Write 32'h0000_0055 with be 4'b0001 to BASE+8, then read BASE+8 → 32'hDEADBE55.
- Read BASE+4*MEM_WORDS and read BASE-4 → each acknowledged with read_data 0. err_count=2 with macro; port absent without it.
- read=write=1, data 32'h12345678 at BASE → acknowledged. A later read of BASE returns 32'h12345678. err_count +1.
- reset_n=0 for one cycle during WAIT of a write to BASE+12 → no acknowledge, RAM[3] unchanged. The next request completes with normal latency.
- Initiator model holds read high until the cycle after acknowledge, repeated 100 times over random in-range addresses → exactly 100 acknowledges, no double service, data matches the reference memory.
